// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: address width, opcodes and the IF/ID payload.
package mips_pkg;

  localparam int unsigned ADDR_W = 6;

  localparam logic [5:0]  OPC_J    = 6'b000010;
  localparam logic [31:0] NOP_WORD = 32'h0;

  typedef struct packed {
    logic [31:0]       instr;
    logic [ADDR_W-1:0] pc;
    logic              pred_taken;
  } ifid_t;

endpackage

// File: rtl/if_pc_gen.sv
// Next-PC select for the fetch stage: redirect, early jump, sequential or hold.
// Early jump decode is present only when IF_STAGE_EARLY_JUMP_EN is defined.
module if_pc_gen #(
  parameter int unsigned ADDR_W = mips_pkg::ADDR_W
) (
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              redirect_valid_i,
  input  logic [ADDR_W-1:0] redirect_target_i,
  input  logic              load_i,
  input  logic              fetch_en_i,
`ifdef IF_STAGE_EARLY_JUMP_EN
  input  logic [5:0]        opcode_i,
  input  logic [ADDR_W-1:0] jump_target_i,
`endif
  output logic              take_jump_c,
  output logic [ADDR_W-1:0] pc_next_c
);

  logic issue;

  assign issue = load_i & fetch_en_i & ~redirect_valid_i;

`ifdef IF_STAGE_EARLY_JUMP_EN
  assign take_jump_c = issue & (opcode_i == mips_pkg::OPC_J);
`else
  assign take_jump_c = 1'b0;
`endif

  // Redirect wins over everything; the +1 wraps naturally at ADDR_W bits.
  always_comb begin
    pc_next_c = pc_i;
    if (redirect_valid_i) begin
      pc_next_c = redirect_target_i;
    end else if (issue) begin
`ifdef IF_STAGE_EARLY_JUMP_EN
      if (take_jump_c) pc_next_c = jump_target_i;
      else             pc_next_c = pc_i + ADDR_W'(1);
`else
      pc_next_c = pc_i + ADDR_W'(1);
`endif
    end
  end

endmodule

// File: rtl/if_stage.sv
// MIPS instruction-fetch stage: PC, imem address, IF/ID register with valid/ready
// handshake to decode, and a saturating delivered-instruction counter.
// Optional zero-bubble J handling enabled by IF_STAGE_EARLY_JUMP_EN.
module if_stage #(
  parameter int unsigned ADDR_W   = mips_pkg::ADDR_W,
  parameter int unsigned RESET_PC = 0,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  output logic              ifid_valid,
  output logic [31:0]       ifid_instr,
  output logic [ADDR_W-1:0] ifid_pc,
  output logic              ifid_pred_taken,
  input  logic              id_ready,
  output logic [CNT_W-1:0]  fetch_count
);

  import mips_pkg::*;

  localparam int unsigned PKG_W = mips_pkg::ADDR_W;

  logic [ADDR_W-1:0] pc_q, pc_d;
  ifid_t             ifid_q, ifid_d;
  logic              valid_q, valid_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              load, accept, take_jump;

  assign load   = ~valid_q | id_ready;
  assign accept = valid_q & id_ready;

  if_pc_gen #(.ADDR_W(ADDR_W)) u_pc_gen (
    .pc_i              (pc_q),
    .redirect_valid_i  (redirect_valid),
    .redirect_target_i (redirect_target),
    .load_i            (load),
    .fetch_en_i        (fetch_en),
`ifdef IF_STAGE_EARLY_JUMP_EN
    .opcode_i          (imem_data[31:26]),
    .jump_target_i     (imem_data[ADDR_W-1:0]),
`endif
    .take_jump_c       (take_jump),
    .pc_next_c         (pc_d)
  );

  // IF/ID next state: redirect flushes, load captures or bubbles, else hold.
  always_comb begin
    ifid_d  = ifid_q;
    valid_d = valid_q;
    if (redirect_valid) begin
      valid_d = 1'b0;
    end else if (load) begin
      if (fetch_en) begin
        ifid_d.instr      = imem_data;
        ifid_d.pc         = PKG_W'(pc_q);
        ifid_d.pred_taken = take_jump;
        valid_d           = 1'b1;
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  // Saturating count of instructions handed to decode.
  always_comb begin
    cnt_d = cnt_q;
    if (accept && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= ADDR_W'(RESET_PC);
      ifid_q  <= '{instr: NOP_WORD, pc: '0, pred_taken: 1'b0};
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      pc_q    <= pc_d;
      ifid_q  <= ifid_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign imem_addr       = pc_q;
  assign ifid_valid      = valid_q;
  assign ifid_instr      = ifid_q.instr;
  assign ifid_pc         = ADDR_W'(ifid_q.pc);
  assign ifid_pred_taken = ifid_q.pred_taken;
  assign fetch_count     = cnt_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a 64-word combinational imem model.
module tb_if_stage;

  localparam int unsigned AW = 6;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          fetch_en;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_data;
  logic          redirect_valid;
  logic [AW-1:0] redirect_target;
  logic          ifid_valid;
  logic [31:0]   ifid_instr;
  logic [AW-1:0] ifid_pc;
  logic          ifid_pred_taken;
  logic          id_ready;
  logic [CW-1:0] fetch_count;

  logic [31:0] mem [64];
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  assign imem_data = mem[imem_addr];

  if_stage #(.ADDR_W(AW), .RESET_PC(0), .CNT_W(CW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .fetch_en        (fetch_en),
    .imem_addr       (imem_addr),
    .imem_data       (imem_data),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .ifid_valid      (ifid_valid),
    .ifid_instr      (ifid_instr),
    .ifid_pc         (ifid_pc),
    .ifid_pred_taken (ifid_pred_taken),
    .id_ready        (id_ready),
    .fetch_count     (fetch_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset for one edge with default inputs; first load happens on the next edge.
  task automatic do_reset();
    rst_n = 1'b0; fetch_en = 1'b1; id_ready = 1'b1;
    redirect_valid = 1'b0; redirect_target = '0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; fetch_en = 1'b1; id_ready = 1'b1;
    redirect_valid = 1'b0; redirect_target = '0;
    #2;
    tests++;
    if ({ifid_valid, ifid_instr, ifid_pc, ifid_pred_taken, fetch_count, imem_addr} !== '0) begin
      fails++;
      $display("FAIL reset: valid=%b instr=%h pc=%0d pt=%b cnt=%0d addr=%0d, expected all 0",
               ifid_valid, ifid_instr, ifid_pc, ifid_pred_taken, fetch_count, imem_addr);
    end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_stream();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      tick();
      tests++;
      if (ifid_valid !== 1'b1 || ifid_pc !== AW'(i) || imem_addr !== AW'(i + 1) ||
          fetch_count !== CW'(i)) begin
        fails++;
        $display("FAIL stream[%0d]: valid=%b pc=%0d addr=%0d cnt=%0d, expected 1 %0d %0d %0d",
                 i, ifid_valid, ifid_pc, imem_addr, fetch_count, i, i + 1, i);
      end
    end
    tests++;
    if (fetch_count !== CW'(5)) begin
      fails++;
      $display("FAIL stream_count: got %0d expected 5", fetch_count);
    end
    do_reset();
    tick();
    tests++;
    if (ifid_instr !== 32'h00084020 || ifid_pc !== AW'(0)) begin
      fails++;
      $display("FAIL first_word: instr=%h pc=%0d expected 00084020 0", ifid_instr, ifid_pc);
    end
  endtask

  task automatic test_stall();
    do_reset();
    tick(); tick(); tick();
    id_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if (ifid_valid !== 1'b1 || ifid_instr !== 32'had090000 || ifid_pc !== AW'(2) ||
          imem_addr !== AW'(3) || fetch_count !== CW'(2)) begin
        fails++;
        $display("FAIL stall[%0d]: v=%b instr=%h pc=%0d addr=%0d cnt=%0d, expected 1 ad090000 2 3 2",
                 i, ifid_valid, ifid_instr, ifid_pc, imem_addr, fetch_count);
      end
    end
    id_ready = 1'b1;
    tick();
    tests++;
    if (ifid_pc !== AW'(3) || ifid_instr !== mem[3] || imem_addr !== AW'(4) ||
        fetch_count !== CW'(3)) begin
      fails++;
      $display("FAIL stall_release: pc=%0d instr=%h addr=%0d cnt=%0d, expected 3 %h 4 3",
               ifid_pc, ifid_instr, imem_addr, fetch_count, mem[3]);
    end
    tick();
    tests++;
    if (ifid_pc !== AW'(4)) begin
      fails++;
      $display("FAIL stall_next: pc=%0d expected 4", ifid_pc);
    end
  endtask

  task automatic test_redirect();
    do_reset();
    redirect_valid = 1'b1; redirect_target = AW'(15);
    tick();
    redirect_valid = 1'b0;
    tick();
    tests++;
    if (ifid_valid !== 1'b1 || ifid_pc !== AW'(15) || imem_addr !== AW'(16)) begin
      fails++;
      $display("FAIL redir_setup: v=%b pc=%0d addr=%0d, expected 1 15 16", ifid_valid, ifid_pc, imem_addr);
    end
    id_ready = 1'b0; redirect_valid = 1'b1; redirect_target = AW'(21);
    tick();
    tests++;
    if (ifid_valid !== 1'b0 || imem_addr !== AW'(21)) begin
      fails++;
      $display("FAIL redir_flush: v=%b addr=%0d, expected 0 21", ifid_valid, imem_addr);
    end
    redirect_valid = 1'b0; id_ready = 1'b1;
    tick();
    tests++;
    if (ifid_valid !== 1'b1 || ifid_instr !== 32'hac0a0100 || ifid_pc !== AW'(21) ||
        imem_addr !== AW'(22) || fetch_count !== CW'(0)) begin
      fails++;
      $display("FAIL redir_target: v=%b instr=%h pc=%0d addr=%0d cnt=%0d, expected 1 ac0a0100 21 22 0",
               ifid_valid, ifid_instr, ifid_pc, imem_addr, fetch_count);
    end
    // Redirect to the current pc while decode accepts: flush plus count.
    redirect_valid = 1'b1; redirect_target = AW'(22);
    tick();
    tests++;
    if (ifid_valid !== 1'b0 || imem_addr !== AW'(22) || fetch_count !== CW'(1)) begin
      fails++;
      $display("FAIL redir_self: v=%b addr=%0d cnt=%0d, expected 0 22 1", ifid_valid, imem_addr, fetch_count);
    end
    redirect_valid = 1'b0;
    tick();
    tests++;
    if (ifid_valid !== 1'b1 || ifid_pc !== AW'(22) || imem_addr !== AW'(23)) begin
      fails++;
      $display("FAIL redir_self_next: v=%b pc=%0d addr=%0d, expected 1 22 23", ifid_valid, ifid_pc, imem_addr);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    redirect_valid = 1'b1; redirect_target = AW'(63);
    tick();
    redirect_valid = 1'b0;
    tick();
    tests++;
    if (ifid_pc !== AW'(63) || ifid_valid !== 1'b1 || imem_addr !== AW'(0)) begin
      fails++;
      $display("FAIL wrap63: v=%b pc=%0d addr=%0d, expected 1 63 0", ifid_valid, ifid_pc, imem_addr);
    end
    tick();
    tests++;
    if (ifid_pc !== AW'(0) || ifid_instr !== 32'h00084020 || imem_addr !== AW'(1)) begin
      fails++;
      $display("FAIL wrap0: pc=%0d instr=%h addr=%0d, expected 0 00084020 1", ifid_pc, ifid_instr, imem_addr);
    end
  endtask

  task automatic test_early_jump();
    do_reset();
    redirect_valid = 1'b1; redirect_target = AW'(20);
    tick();
    redirect_valid = 1'b0;
    tick();
    tests++;
`ifdef IF_STAGE_EARLY_JUMP_EN
    if (ifid_instr !== 32'h0800000e || ifid_pred_taken !== 1'b1 || imem_addr !== AW'(14)) begin
      fails++;
      $display("FAIL jump_issue: instr=%h pt=%b addr=%0d, expected 0800000e 1 14",
               ifid_instr, ifid_pred_taken, imem_addr);
    end
`else
    if (ifid_instr !== 32'h0800000e || ifid_pred_taken !== 1'b0 || imem_addr !== AW'(21)) begin
      fails++;
      $display("FAIL jump_issue: instr=%h pt=%b addr=%0d, expected 0800000e 0 21",
               ifid_instr, ifid_pred_taken, imem_addr);
    end
`endif
    tick();
    tests++;
`ifdef IF_STAGE_EARLY_JUMP_EN
    if (ifid_valid !== 1'b1 || ifid_pc !== AW'(14) || ifid_pred_taken !== 1'b0) begin
      fails++;
      $display("FAIL jump_target: v=%b pc=%0d pt=%b, expected 1 14 0", ifid_valid, ifid_pc, ifid_pred_taken);
    end
`else
    if (ifid_valid !== 1'b1 || ifid_pc !== AW'(21) || ifid_pred_taken !== 1'b0) begin
      fails++;
      $display("FAIL jump_target: v=%b pc=%0d pt=%b, expected 1 21 0", ifid_valid, ifid_pc, ifid_pred_taken);
    end
`endif
  endtask

  task automatic test_fetch_en();
    do_reset();
    tick();
    fetch_en = 1'b0;
    tick();
    tests++;
    if (ifid_valid !== 1'b0 || imem_addr !== AW'(1) || fetch_count !== CW'(1)) begin
      fails++;
      $display("FAIL fetch_off: v=%b addr=%0d cnt=%0d, expected 0 1 1", ifid_valid, imem_addr, fetch_count);
    end
    tick();
    tests++;
    if (ifid_valid !== 1'b0 || imem_addr !== AW'(1)) begin
      fails++;
      $display("FAIL fetch_off_hold: v=%b addr=%0d, expected 0 1", ifid_valid, imem_addr);
    end
    fetch_en = 1'b1;
    tick();
    tests++;
    if (ifid_valid !== 1'b1 || ifid_pc !== AW'(1) || imem_addr !== AW'(2)) begin
      fails++;
      $display("FAIL fetch_resume: v=%b pc=%0d addr=%0d, expected 1 1 2", ifid_valid, ifid_pc, imem_addr);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 15 || k == 16 || k == 20) begin
        tests++;
        if (fetch_count !== CW'((k - 1 > 15) ? 15 : k - 1)) begin
          fails++;
          $display("FAIL saturate[%0d]: got %0d expected %0d", k, fetch_count, (k - 1 > 15) ? 15 : k - 1);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int k = 0; k < 8; k++) tick();
    id_ready = 1'b0;
    tick();
    tests++;
    if (fetch_count !== CW'(7) || ifid_pc !== AW'(7)) begin
      fails++;
      $display("FAIL areset_pre: cnt=%0d pc=%0d, expected 7 7", fetch_count, ifid_pc);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({ifid_valid, ifid_instr, ifid_pc, ifid_pred_taken, fetch_count, imem_addr} !== '0) begin
      fails++;
      $display("FAIL areset_now: v=%b instr=%h pc=%0d cnt=%0d addr=%0d, expected all 0",
               ifid_valid, ifid_instr, ifid_pc, fetch_count, imem_addr);
    end
    tick();
    rst_n = 1'b1; id_ready = 1'b1;
    tick();
    tests++;
    if (ifid_valid !== 1'b1 || ifid_pc !== AW'(0) || ifid_instr !== 32'h00084020 ||
        imem_addr !== AW'(1) || fetch_count !== CW'(0)) begin
      fails++;
      $display("FAIL areset_resume: v=%b pc=%0d instr=%h addr=%0d cnt=%0d, expected 1 0 00084020 1 0",
               ifid_valid, ifid_pc, ifid_instr, imem_addr, fetch_count);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = {8'h20, 24'(i)};
    mem[0]  = 32'h00084020;
    mem[2]  = 32'had090000;
    mem[20] = 32'h0800000e;
    mem[21] = 32'hac0a0100;

    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_wrap();
    test_early_jump();
    test_fetch_en();
    test_saturate();
    test_async_reset();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the MIPS core; sits directly upstream of the 64-word combinational instruction memory.
- Owns the program counter and drives the word address into imem.
- Captures the returned 32-bit instruction into an IF/ID pipeline register, with a valid/ready handshake to decode.
- Handles stall, branch/jump redirect with flush, PC wrap-around, and a delivered-instruction counter.

Parameters:
ADDR_W, 6, PC / imem word-address width; PC counts words, not bytes.
RESET_PC, 0, word address loaded into PC on reset.
CNT_W, 16, width of the delivered-instruction counter.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  reset, asynchronous, active-low.
fetch_en  in  1  1 = fetch allowed; 0 = PC holds, no new instructions issued.
imem_addr  out  ADDR_W  word address to imem; equals current PC combinationally.
imem_data  in  32  instruction from imem, valid in the same cycle as imem_addr.
redirect_valid  in  1  taken branch/jump resolved downstream.
redirect_target  in  ADDR_W  word address to resume fetch from.
ifid_valid  out  1  IF/ID register holds a valid instruction.
ifid_instr  out  32  registered instruction.
ifid_pc  out  ADDR_W  word address of ifid_instr.
ifid_pred_taken  out  1  fetch already redirected PC for this instruction (early jump).
id_ready  in  1  decode accepts ifid_* this cycle.
fetch_count  out  CNT_W  number of instructions accepted by decode.

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC, ifid_valid=0, ifid_instr=32'h0, ifid_pc=0, ifid_pred_taken=0, fetch_count=0. All outputs hold these values while rst_n=0. Reset asserted mid-fetch discards all in-flight state.
- Definitions: load = ~ifid_valid | id_ready; accept = ifid_valid & id_ready.
- Priority at each rising edge: redirect > load > hold.
  - Redirect (redirect_valid=1): pc<=redirect_target; ifid_valid<=0 (flush), regardless of id_ready or fetch_en; ifid_instr/ifid_pc may hold. Accept in the same cycle still counts.
  - Load with fetch_en=1: ifid_instr<=imem_data; ifid_pc<=pc; ifid_valid<=1; pc<=pc+1 modulo 2^ADDR_W (63 wraps to 0).
  - Load with fetch_en=0: ifid_valid<=0; pc holds.
  - Hold (ifid_valid=1, id_ready=0, no redirect): all IF/ID fields and pc unchanged. imem_addr stays stable.
- Latency: an instruction at address A appears on ifid_* 1 cycle after pc=A. Steady-state throughput is 1 instruction/cycle. A redirect costs 1 bubble cycle (ifid_valid=0), then the target is valid.
- fetch_count: increments by 1 on each accept and saturates at all-ones (no wrap). It is cleared only by reset.
- Redirect to the current pc value is legal: the flush still occurs.

Optional Feature:
- Macro: IF_STAGE_EARLY_JUMP_EN.
- Defined: on a load with fetch_en=1 and no redirect, if imem_data[31:26]==6'b000010 (J), then pc<=imem_data[ADDR_W-1:0] instead of pc+1, and ifid_pred_taken<=1. Decode must not re-redirect for instructions with ifid_pred_taken=1. Result: zero bubble for J.
- Undefined: ifid_pred_taken is constant 0; J is handled only through redirect_valid.

Decomposition:
- Shared package mips_pkg:
  - ADDR_W default constant
  - OPC_J = 6'b000010
  - NOP_WORD = 32'h0
  - typedef ifid_t {instr, pc, pred_taken}
- One sub-module, if_pc_gen: combinational next-PC select (redirect / early jump / +1 / hold). IF/ID register and counter stay in if_stage.

Test Plan:
- Reset then fetch_en=1, id_ready=1 on program word 0 = 32'h00084020 -> cycle 1: ifid_valid=1, ifid_instr=32'h00084020, ifid_pc=0; pc increments by 1 per cycle; fetch_count=5 after 5 accepts.
- id_ready=0 for 3 cycles at ifid_pc=2 -> ifid_instr stays 32'had090000, pc stays 3; on release, ifid_pc=3 next cycle with no duplicate and no skip.
- beq at word 15 resolved: redirect_valid=1, target=21 while id_ready=0 -> next cycle ifid_valid=0, pc=21; following cycle ifid_instr=32'hac0a0100, ifid_pc=21.
- pc=63 with load -> next pc=0; ifid_pc=63 delivered, then ifid_pc=0.
- IF_STAGE_EARLY_JUMP_EN defined, fetch word 20 = 32'h0800000e -> ifid_pred_taken=1 and pc=14 next cycle, no bubble. Undefined -> pc=21, ifid_pred_taken=0.
- rst_n pulsed low mid-stall with fetch_count=7 -> all outputs zero immediately (async), pc=RESET_PC, fetch resumes from word 0 after release.
